// File: rtl/sequencer_v2_core.sv
// sequencer_v2_core: program sequencer running from an internal instruction RAM.
// Drives a timed output pattern, supports nested hardware loops, wait-for-trigger,
// repeat mode and reports errors with a cause code.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | stopped, waiting for run; RAM writable
//   S_FETCH | RAM read of mem[pc] in flight
//   S_EXEC  | decode and act on the fetched word
//   S_DWELL | hold seq_out for the OUT dwell time (down-counter)
//   S_WAITT | stalled on WAIT_TRIG until trig = 1
//   S_DONE  | END reached, eos = 1; RAM writable
//   S_ERROR | fault, err = 1 and err_code valid; RAM writable
module sequencer_v2_core #(
   parameter  int OUT_W      = 32,
   parameter  int ADDR_W     = 10,
   parameter  int TIME_W     = 16,
   parameter  int CNT_W      = 16,
   parameter  int LOOP_DEPTH = 4,
   localparam int INSTR_W    = 4 + TIME_W + OUT_W
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [INSTR_W-1:0] wr_data,
   input  logic               run_sw,
   input  logic               run_ext,
   input  logic               run_src,
   input  logic               repeat_en,
   input  logic               trig,
   output logic [OUT_W-1:0]   seq_out,
   output logic               eos,
   output logic               busy,
   output logic               err,
   output logic [2:0]         err_code
);

   localparam int SPW    = $clog2(LOOP_DEPTH + 1);
   localparam int SDEPTH = 2 ** SPW;
   localparam logic [SPW-1:0] SP_FULL = SPW'(LOOP_DEPTH);

   localparam logic [3:0] OP_NOP     = 4'd0;
   localparam logic [3:0] OP_OUT     = 4'd1;
   localparam logic [3:0] OP_LOOP    = 4'd2;
   localparam logic [3:0] OP_ENDLOOP = 4'd3;
   localparam logic [3:0] OP_END     = 4'd4;
   localparam logic [3:0] OP_WAIT    = 4'd5;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_EXEC, S_DWELL, S_WAITT, S_DONE, S_ERROR
   } state_t;

   state_t              state, state_nx, step_to;
   logic [INSTR_W-1:0]  mem [2**ADDR_W];
   logic [INSTR_W-1:0]  instr;
   logic [ADDR_W-1:0]   pc, pc_nx, pc_inc;
   logic [SPW-1:0]      sp, sp_nx, sp_top;
   logic [TIME_W-1:0]   dwell_cnt, dwell_nx;
   logic [OUT_W-1:0]    seq_out_nx;
   logic [2:0]          err_code_nx;
   logic [ADDR_W-1:0]   stk_addr [SDEPTH];
   logic [CNT_W-1:0]    stk_cnt  [SDEPTH];
   logic [CNT_W-1:0]    n_fld, top_cnt;
   logic [3:0]          op;
   logic [TIME_W-1:0]   t_fld;
   logic [OUT_W-1:0]    d_fld;
   logic                run, push, dec_top, step;

   assign run     = run_src ? run_ext : run_sw;
   assign op      = instr[INSTR_W-1 -: 4];
   assign t_fld   = instr[OUT_W +: TIME_W];
   assign d_fld   = instr[OUT_W-1:0];
   assign n_fld   = (d_fld[CNT_W-1:0] == '0) ? CNT_W'(1) : d_fld[CNT_W-1:0];
   assign pc_inc  = pc + 1'b1;
   assign sp_top  = sp - 1'b1;
   assign top_cnt = stk_cnt[sp_top];

   assign busy = (state == S_FETCH) || (state == S_EXEC) ||
                 (state == S_DWELL) || (state == S_WAITT);
   assign eos  = (state == S_DONE);
   assign err  = (state == S_ERROR);

   // Instruction RAM: writes only while stopped, read data registered every cycle.
   always_ff @(posedge aclk) begin
      if (wr_en && !busy)
         mem[wr_addr] <= wr_data;
      instr <= mem[pc];
   end

   // Loop stack storage; the pointer sp alone defines validity, so no reset needed.
   always_ff @(posedge aclk) begin
      if (push) begin
         stk_addr[sp] <= pc_inc;
         stk_cnt[sp]  <= n_fld;
      end
      if (dec_top)
         stk_cnt[sp_top] <= top_cnt - 1'b1;
   end

   // Next-state, pc, stack and output decode.
   always_comb begin
      state_nx    = state;
      pc_nx       = pc;
      sp_nx       = sp;
      dwell_nx    = dwell_cnt;
      seq_out_nx  = seq_out;
      err_code_nx = err_code;
      push        = 1'b0;
      dec_top     = 1'b0;
      step        = 1'b0;
      step_to     = S_FETCH;

      case (state)
         S_IDLE: begin
            if (run) begin
               state_nx = S_FETCH;
               pc_nx    = '0;
               sp_nx    = '0;
            end
         end
         S_FETCH: state_nx = S_EXEC;
         S_EXEC: begin
            case (op)
               OP_NOP: step = 1'b1;
               OP_OUT: begin
                  seq_out_nx = d_fld;
                  step       = 1'b1;
                  if (t_fld != '0) begin
                     dwell_nx = t_fld;
                     step_to  = S_DWELL;
                  end
               end
               OP_LOOP: begin
                  if (sp == SP_FULL) begin
                     state_nx    = S_ERROR;
                     err_code_nx = 3'd2;
                  end else begin
                     push  = 1'b1;
                     sp_nx = sp + 1'b1;
                     step  = 1'b1;
                  end
               end
               OP_ENDLOOP: begin
                  if (sp == '0) begin
                     state_nx    = S_ERROR;
                     err_code_nx = 3'd3;
                  end else if (top_cnt > CNT_W'(1)) begin
                     dec_top  = 1'b1;
                     pc_nx    = stk_addr[sp_top];
                     state_nx = S_FETCH;
                  end else begin
                     sp_nx = sp_top;
                     step  = 1'b1;
                  end
               end
               OP_END: begin
                  if (repeat_en) begin
                     pc_nx    = '0;
                     sp_nx    = '0;
                     state_nx = S_FETCH;
                  end else begin
                     state_nx = S_DONE;
                  end
               end
               OP_WAIT: begin
                  if (trig) step = 1'b1;
                  else      state_nx = S_WAITT;
               end
               default: begin
                  state_nx    = S_ERROR;
                  err_code_nx = 3'd1;
               end
            endcase
         end
         S_DWELL: begin
            dwell_nx = dwell_cnt - 1'b1;
            if (dwell_cnt == TIME_W'(1))
               state_nx = S_FETCH;
         end
         S_WAITT: begin
            if (trig) step = 1'b1;
         end
         default: ;
      endcase

      // Sequential advance; running off the top of the RAM is a fault, not a wrap.
      if (step) begin
         if (&pc) begin
            state_nx    = S_ERROR;
            err_code_nx = 3'd4;
         end else begin
            pc_nx    = pc_inc;
            state_nx = step_to;
         end
      end

      // Dropping run wins over everything and leaves seq_out untouched.
      if (state != S_IDLE && !run) begin
         state_nx    = S_IDLE;
         err_code_nx = '0;
         seq_out_nx  = seq_out;
         push        = 1'b0;
         dec_top     = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= S_IDLE;
      else          state <= state_nx;
   end

   // Datapath registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pc        <= '0;
         sp        <= '0;
         dwell_cnt <= '0;
         seq_out   <= '0;
         err_code  <= '0;
      end else begin
         pc        <= pc_nx;
         sp        <= sp_nx;
         dwell_cnt <= dwell_nx;
         seq_out   <= seq_out_nx;
         err_code  <= err_code_nx;
      end
   end

endmodule
